// File: rtl/seg7_pkg.sv
// Shared types and glyph decoding for the 7-segment display controller.
// Glyphs are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } dd_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg_n(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter: one bit per SHIFT cycle,
// then a single LATCH cycle that presents the result with done high.
module bin2bcd_dd
    import seg7_pkg::*;
#(
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned SR_W  = 4 * (NUM_DIGITS + 2);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    dd_state_t          state, state_next;
    logic [BIN_W-1:0]   bin_reg, bin_next;
    logic [SR_W-1:0]    sr, sr_next, sr_adj;
    logic [CNT_W-1:0]   cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_reg <= '0;
            sr      <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            bin_reg <= bin_next;
            sr      <= sr_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        bin_next   = bin_reg;
        sr_next    = sr;
        cnt_next   = cnt;
        sr_adj     = sr;
        for (int unsigned i = 0; i < NUM_DIGITS + 2; i++) begin
            if (sr[4*i +: 4] >= 4'd5)
                sr_adj[4*i +: 4] = sr[4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    bin_next   = bin;
                    sr_next    = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sr_next  = {sr_adj[SR_W-2:0], bin_reg[BIN_W-1]};
                bin_next = bin_reg << 1;
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_W'(BIN_W - 1))
                    state_next = LATCH;
            end
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == LATCH);
    assign bcd  = sr[4*NUM_DIGITS-1:0];
    assign ovf  = |sr[SR_W-1:4*NUM_DIGITS];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit common-anode 7-segment driver: converts, holds and scans a value.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    dd_done, dd_ovf;
    logic [4*NUM_DIGITS-1:0] dd_bcd;

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic                    ovf_reg;
    logic [3:0]              digit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    bin2bcd_dd #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_dd (
        .clk   (clk),
        .rst   (rst),
        .start (bin_valid),
        .bin   (bin_in),
        .busy  (busy),
        .done  (dd_done),
        .ovf   (dd_ovf),
        .bcd   (dd_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            display_reg <= '0;
            ovf_reg     <= 1'b0;
            an_n        <= '1;
            seg_n       <= SEG_BLANK;
        end else begin
            if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
                prescaler <= '0;
                idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (dd_done) begin
                display_reg <= dd_bcd;
                ovf_reg     <= dd_ovf;
            end
            an_n  <= an_next;
            seg_n <= seg_next;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  above_zero;

    // lead_zero[i] is set when digit i and everything above it are zero; digit 0 never blanks
    always_comb begin
        lead_zero  = '0;
        above_zero = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            above_zero   = above_zero && (display_reg[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero;
        end
    end
`endif

    always_comb begin
        digit   = display_reg[idx*4 +: 4];
        an_next = ~(NUM_DIGITS'(1) << idx);
        if (ovf_reg)
            seg_next = SEG_DASH;
        else
            seg_next = bcd_to_seg_n(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (!ovf_reg && lead_zero[idx])
            seg_next = SEG_BLANK;
`endif
    end

    assign ovf = ovf_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with REFRESH_DIV=4, NUM_DIGITS=4, BIN_W=14.
module tb_seg7_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bin_valid;
    logic [13:0] bin_in;
    logic        busy;
    logic        ovf;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .BIN_W       (14),
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .busy      (busy),
        .ovf       (ovf),
        .an_n      (an_n),
        .seg_n     (seg_n)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z = 7'h7F;
`else
    localparam logic [6:0] Z = 7'h40;
`endif

    typedef struct {
        logic [13:0]     value;
        logic [3:0][6:0] seg;
        logic            ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [13:0] v);
        bin_in    = v;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_slot(input int k, input logic [6:0] exp, input string name);
        logic [3:0] pat;
        int t;
        pat = ~(4'b0001 << k);
        t = 0;
        tick();
        while (an_n !== pat && t < 20) begin
            t++;
            tick();
        end
        check({name, " an"}, {28'd0, an_n}, {28'd0, pat});
        check({name, " seg"}, {25'd0, seg_n}, {25'd0, exp});
    endtask

    initial begin
        int n;
        logic [3:0] scan_exp [4];

        vecs[0] = '{14'd1234,  {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        vecs[1] = '{14'd9999,  {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0};
        vecs[2] = '{14'd10000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[3] = '{14'd5,     {Z,     Z,     Z,     7'h12}, 1'b0};
        vecs[4] = '{14'd42,    {Z,     Z,     7'h19, 7'h24}, 1'b0};
        vecs[5] = '{14'd0,     {Z,     Z,     Z,     7'h40}, 1'b0};
        vecs[6] = '{14'd16383, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[7] = '{14'd8765,  {7'h00, 7'h78, 7'h02, 7'h12}, 1'b0};
        scan_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        rst       = 1'b1;
        bin_valid = 1'b0;
        bin_in    = '0;
        repeat (3) tick();
        check("rst an_n", {28'd0, an_n}, 32'hF);
        check("rst seg_n", {25'd0, seg_n}, 32'h7F);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst ovf", {31'd0, ovf}, 32'd0);

        rst = 1'b0;
        tick();
        check("scan first", {28'd0, an_n}, 32'hE);
        for (int unsigned j = 0; j < 4; j++) begin
            repeat (4) tick();
            check($sformatf("scan step%0d", j), {28'd0, an_n}, {28'd0, scan_exp[j]});
        end

        for (int unsigned i = 0; i < 8; i++) begin
            load(vecs[i].value);
            wait_idle(n);
            check($sformatf("v%0d busy_cycles", i), n, 32'd15);
            check($sformatf("v%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
            for (int k = 0; k < 4; k++)
                check_slot(k, vecs[i].seg[k], $sformatf("v%0d slot%0d", i, k));
        end

        // load while busy is dropped, not queued
        load(14'd1234);
        repeat (3) tick();
        bin_in    = 14'd777;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        wait_idle(n);
        check("ignore remaining busy", n, 32'd11);
        tick();
        check("ignore no requeue", {31'd0, busy}, 32'd0);
        check_slot(0, 7'h19, "ignore slot0");
        check_slot(1, 7'h30, "ignore slot1");
        check_slot(2, 7'h24, "ignore slot2");
        check_slot(3, 7'h79, "ignore slot3");

        // load accepted in the IDLE cycle right after LATCH
        load(14'd1111);
        wait_idle(n);
        load(14'd2222);
        wait_idle(n);
        check("b2b busy_cycles", n, 32'd15);
        for (int k = 0; k < 4; k++)
            check_slot(k, 7'h24, $sformatf("b2b slot%0d", k));

        // reset mid-SHIFT aborts without latching
        load(14'd4321);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("abort busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("abort ovf", {31'd0, ovf}, 32'd0);
        check("abort busy later", {31'd0, busy}, 32'd0);
        check_slot(0, 7'h40, "abort slot0");
        check_slot(3, Z, "abort slot3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
